// File: rtl/change_pkg.sv
// change_pkg: shared types and constants for the change dispenser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package change_pkg;

  // Payout FSM states
  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    PULSE,
    GAP,
    DONE
  } state_t;

  // Denomination values in dollars
  localparam int COIN5 = 5;
  localparam int COIN2 = 2;
  localparam int COIN1 = 1;

  // Tube indices; these match the bit positions of tube_empty {5,2,1}
  localparam logic [1:0] IDX1 = 2'd0;
  localparam logic [1:0] IDX2 = 2'd1;
  localparam logic [1:0] IDX5 = 2'd2;
  localparam int         NUM_TUBES = 3;

  // Tube stock counter width (max 15 coins per tube)
  localparam int TUBE_W = 4;

  // Dollar value of the coin held in a given tube
  function automatic logic [2:0] coin_val(input logic [1:0] idx);
    case (idx)
      IDX5:    return 3'(COIN5);
      IDX2:    return 3'(COIN2);
      default: return 3'(COIN1);
    endcase
  endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// coin_pulse_timer: down-counter timing the solenoid high phase and the low gap after it.
// Latency: last_pulse asserts PULSE_CYCLES-1 cycles after load_pulse; gap_done GAP_CYCLES-1 after load_gap.
// Backpressure: none; the FSM owns sequencing, the timer only counts.
// Ports: clk, rst (sync, active-high); load_pulse/load_gap reload the counter;
//        in_pulse/in_gap qualify the flags; last_pulse/gap_done report phase end.
module coin_pulse_timer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load_pulse,
  input  logic load_gap,
  input  logic in_pulse,
  input  logic in_gap,
  output logic last_pulse,
  output logic gap_done
);

  localparam int MAXC  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [CNT_W-1:0] cnt;

  // The counter holds "cycles left after this one", so zero marks the final cycle of a phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load_pulse) begin
      cnt <= CNT_W'(PULSE_CYCLES - 1);
    end else if (load_gap) begin
      cnt <= CNT_W'(GAP_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last_pulse = in_pulse && (cnt == '0);
  assign gap_done   = in_gap   && (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy $5/$2/$1 payout of a change amount through coin-hopper solenoids.
// Latency: first solenoid high two cycles after start is sampled; each coin takes PULSE+GAP+1 cycles.
// Backpressure: start/refill are ignored while busy (not queued); refill beats start in IDLE.
// Ports: clk, rst (sync, active-high); start/amount request a payout; refill reloads tubes;
//        busy/done/short/remaining report progress; payout_coin5/2/1 drive solenoids;
//        tube_empty {5,2,1} flags empty tubes. Define CHANGE_AUDIT_EN to add audit_total[15:0].
module change_dispenser
  import change_pkg::*;
#(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int TUBE_INIT    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             refill,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic             payout_coin5,
  output logic             payout_coin2,
  output logic             payout_coin1,
  output logic [2:0]       tube_empty
`ifdef CHANGE_AUDIT_EN
  ,
  output logic [15:0]      audit_total
`endif
);

  state_t              state, state_nxt;
  logic [AMT_W-1:0]    remaining_q;
  logic                short_q;
  logic [1:0]          sel_idx;
  logic [TUBE_W-1:0]   tube_q [NUM_TUBES];

  logic                pick_vld;
  logic [1:0]          pick_idx;
  logic                last_pulse;
  logic                gap_done;
  logic [AMT_W-1:0]    sel_amt;

  assign sel_amt = AMT_W'(coin_val(sel_idx));

  // Greedy pick: largest coin that fits the balance and is still in stock.
  // A zero balance never qualifies, so !pick_vld covers both completion and shortfall.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = IDX1;
    if ((remaining_q >= AMT_W'(COIN5)) && (tube_q[IDX5] != '0)) begin
      pick_vld = 1'b1;
      pick_idx = IDX5;
    end else if ((remaining_q >= AMT_W'(COIN2)) && (tube_q[IDX2] != '0)) begin
      pick_vld = 1'b1;
      pick_idx = IDX2;
    end else if ((remaining_q >= AMT_W'(COIN1)) && (tube_q[IDX1] != '0)) begin
      pick_vld = 1'b1;
      pick_idx = IDX1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !refill) state_nxt = SELECT;
      SELECT:  state_nxt = pick_vld ? PULSE : DONE;
      PULSE:   if (last_pulse) state_nxt = GAP;
      GAP:     if (gap_done) state_nxt = SELECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      remaining_q <= '0;
      short_q     <= 1'b0;
      sel_idx     <= IDX1;
      for (int i = 0; i < NUM_TUBES; i++) tube_q[i] <= TUBE_W'(TUBE_INIT);
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (refill) begin
            for (int i = 0; i < NUM_TUBES; i++) tube_q[i] <= TUBE_W'(TUBE_INIT);
          end else if (start) begin
            remaining_q <= amount;
            short_q     <= 1'b0;
          end
        end
        SELECT: begin
          if (pick_vld) sel_idx <= pick_idx;
          else          short_q <= (remaining_q != '0);
        end
        PULSE: begin
          // A coin is only counted once its full pulse has been driven.
          if (last_pulse) begin
            remaining_q     <= remaining_q - sel_amt;
            tube_q[sel_idx] <= tube_q[sel_idx] - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  coin_pulse_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_pulse (state == SELECT && pick_vld),
    .load_gap   (last_pulse),
    .in_pulse   (state == PULSE),
    .in_gap     (state == GAP),
    .last_pulse (last_pulse),
    .gap_done   (gap_done)
  );

`ifdef CHANGE_AUDIT_EN
  logic [16:0] audit_sum;
  assign audit_sum = {1'b0, audit_total} + 17'(coin_val(sel_idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      audit_total <= '0;
    end else if (state == PULSE && last_pulse) begin
      audit_total <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
    end
  end
`endif

  // Solenoids decode from registered state so reset drops them on the same edge.
  assign busy         = (state == SELECT) || (state == PULSE) || (state == GAP);
  assign done         = (state == DONE);
  assign short        = short_q;
  assign remaining    = remaining_q;
  assign payout_coin5 = (state == PULSE) && (sel_idx == IDX5);
  assign payout_coin2 = (state == PULSE) && (sel_idx == IDX2);
  assign payout_coin1 = (state == PULSE) && (sel_idx == IDX1);
  assign tube_empty   = {tube_q[IDX5] == '0, tube_q[IDX2] == '0, tube_q[IDX1] == '0};

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized payouts checked against a greedy coin model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_change_dispenser;

  localparam int P     = 4;
  localparam int G     = 4;
  localparam int T     = 10;
  localparam int LIMIT = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] amount;
  logic       refill;
  logic       busy, done, short;
  logic [7:0] remaining;
  logic       payout_coin5, payout_coin2, payout_coin1;
  logic [2:0] tube_empty;
`ifdef CHANGE_AUDIT_EN
  logic [15:0] audit_total;
`endif

  int checks = 0;
  int errors = 0;

  // Model: tube stock indexed 0=$1, 1=$2, 2=$5; lifetime dollars paid
  int m_tube [3];
  int m_audit;

  change_dispenser #(
    .AMT_W(8), .PULSE_CYCLES(P), .GAP_CYCLES(G), .TUBE_INIT(T)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .amount       (amount),
    .refill       (refill),
    .busy         (busy),
    .done         (done),
    .short        (short),
    .remaining    (remaining),
    .payout_coin5 (payout_coin5),
    .payout_coin2 (payout_coin2),
    .payout_coin1 (payout_coin1),
    .tube_empty   (tube_empty)
`ifdef CHANGE_AUDIT_EN
    ,
    .audit_total  (audit_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_empty();
    return ((m_tube[2] == 0) ? 4 : 0) + ((m_tube[1] == 0) ? 2 : 0) + ((m_tube[0] == 0) ? 1 : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_tube[i] = T;
    m_audit = 0;
  endtask

  task automatic do_refill();
    refill = 1'b1;
    step();
    refill = 1'b0;
    for (int i = 0; i < 3; i++) m_tube[i] = T;
    chk("refill_tube_empty", int'(tube_empty), 0);
  endtask

  // mode 0: quiet; 1: random start/refill/amount noise while busy; 2: start(5)+refill held while busy
  task automatic run_payout(input int amt, input int mode, input string name);
    int         rem, sum, cyc, run, oh_bad, busy_bad, got_done, first_on, exp_cyc;
    int         coins[$];
    int         seen_coin[$];
    int         seen_len[$];
    logic [2:0] lines, prev;

    // Reference: greedy payout from current stock, in plain arithmetic
    rem = amt;
    sum = 0;
    for (int guard = 0; guard < 300; guard++) begin
      if (rem >= 5 && m_tube[2] > 0)      begin coins.push_back(5); rem -= 5; m_tube[2]--; end
      else if (rem >= 2 && m_tube[1] > 0) begin coins.push_back(2); rem -= 2; m_tube[1]--; end
      else if (rem >= 1 && m_tube[0] > 0) begin coins.push_back(1); rem -= 1; m_tube[0]--; end
      else break;
    end
    foreach (coins[i]) sum += coins[i];
    m_audit = (m_audit + sum > 65535) ? 65535 : m_audit + sum;
    exp_cyc = 2 + coins.size() * (P + G + 1);

    start  = 1'b1;
    amount = 8'(amt);
    step();
    start    = 1'b0;
    cyc      = 1;
    prev     = 3'b000;
    run      = 0;
    oh_bad   = 0;
    busy_bad = 0;
    got_done = 0;
    first_on = -1;
    while (cyc <= LIMIT) begin
      lines = {payout_coin5, payout_coin2, payout_coin1};
      if ($countones(lines) > 1) oh_bad++;
      if (lines != 3'b000 && first_on < 0) first_on = cyc;
      if (lines != prev) begin
        if (prev != 3'b000) seen_len.push_back(run);
        if (lines != 3'b000) begin
          seen_coin.push_back(lines == 3'b100 ? 5 : (lines == 3'b010 ? 2 : 1));
          run = 1;
        end
      end else if (lines != 3'b000) begin
        run++;
      end
      prev = lines;
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (mode == 1) begin
        start  = 1'($urandom_range(0, 1));
        amount = 8'($urandom_range(0, 255));
        refill = ($urandom_range(0, 3) == 0);
      end else if (mode == 2) begin
        start  = 1'b1;
        amount = 8'd5;
        refill = 1'b1;
      end
      step();
      cyc++;
    end
    start  = 1'b0;
    refill = 1'b0;

    chk({name, "_done_seen"}, got_done, 1);
    chk({name, "_done_cycle"}, cyc, exp_cyc);
    chk({name, "_coin_count"}, seen_coin.size(), coins.size());
    foreach (coins[i]) begin
      chk($sformatf("%s_coin%0d", name, i), (i < seen_coin.size()) ? seen_coin[i] : -1, coins[i]);
      chk($sformatf("%s_len%0d", name, i), (i < seen_len.size()) ? seen_len[i] : -1, P);
    end
    if (coins.size() > 0) chk({name, "_first_line_cycle"}, first_on, 2);
    chk({name, "_onehot"}, oh_bad, 0);
    chk({name, "_busy_during"}, busy_bad, 0);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    chk({name, "_short"}, int'(short), (rem != 0) ? 1 : 0);
    chk({name, "_remaining"}, int'(remaining), rem);
    chk({name, "_tube_empty"}, int'(tube_empty), exp_empty());
    step();
    chk({name, "_done_single"}, int'(done), 0);
    chk({name, "_remaining_hold"}, int'(remaining), rem);
`ifdef CHANGE_AUDIT_EN
    chk({name, "_audit"}, int'(audit_total), m_audit);
`endif
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    refill = 1'b0;
    amount = 8'd0;
    step();
    step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short", int'(short), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_lines", int'({payout_coin5, payout_coin2, payout_coin1}), 0);
    chk("rst_tube_empty", int'(tube_empty), 0);
`ifdef CHANGE_AUDIT_EN
    chk("rst_audit", int'(audit_total), 0);
`endif
    do_reset();

    // Basic greedy mix and the zero-amount path
    run_payout(8, 0, "amt8");
    run_payout(0, 0, "amt0");

    // Empty the $2 tube, then 4 must come out as four $1 coins
    for (int i = 0; i < 4; i++) run_payout(4, 0, "drain2");
    run_payout(2, 0, "drain2_last");
    run_payout(4, 0, "ones4");

    // Empty every tube, then a request must be reported short with no coins
    run_payout(45, 0, "drain5");
    run_payout(5, 0, "drain1");
    run_payout(3, 0, "all_empty");
    do_refill();
    run_payout(3, 0, "after_refill");

    // start/refill while busy must be ignored
    run_payout(8, 2, "busy_ignore");

    // Reset during the second pulse cycle of a $5 coin
    start  = 1'b1;
    amount = 8'd5;
    step();
    start = 1'b0;
    step();
    chk("midrst_pulse1", int'(payout_coin5), 1);
    step();
    chk("midrst_pulse2", int'(payout_coin5), 1);
    do_reset();
    chk("midrst_lines", int'({payout_coin5, payout_coin2, payout_coin1}), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_remaining", int'(remaining), 0);
`ifdef CHANGE_AUDIT_EN
    chk("midrst_audit", int'(audit_total), 0);
`endif
    run_payout(7, 0, "post_rst7");
    run_payout(50, 0, "post_rst50");

    // Randomized payouts with noise on start/refill/amount while busy
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) do_refill();
      run_payout(int'($urandom_range(0, 30)), 1, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
